uart_rx: RTL
============

# uart_rx

Serial receiver for the team's 8N1 UART link. It accepts the line driven by the matching transmitter: idle-high, one low start bit, 8 data bits LSB first, one high stop bit. Each bit is CLKS_PER_BIT clocks long. The block synchronizes the line, samples each bit at its midpoint, checks the stop bit, and presents each byte on a holding register with a valid/ack handshake to the host side (Nios bridge).

## Interface
- CLKS_PER_BIT, default 1: clocks per serial bit, ≥1. The default matches the one-bit-per-clock transmitter.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- rx  in  1  serial line, asynchronous, idle high
- data  out  8  last good byte, stable while valid=1
- valid  out  1  byte available in data
- ack  in  1  host consumes byte; meaningful only while valid=1
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky: a byte was overwritten before ack
- busy  out  1  frame reception in progress (state ≠ IDLE)

## Operation
- **Synchronizer:** rx passes through 2 flops, both reset to 1; the FSM uses only the synchronized value rx_s.
- **Constants and counters:** HALF = (CLKS_PER_BIT-1)/2 (integer). cnt width is clog2(CLKS_PER_BIT), minimum 1 bit. bit_idx is 3 bits. The shift register is 8 bits, and data bit i goes to shift[i].
- **IDLE:**
  - If rx_s=0 and HALF=0: go to DATA with cnt=CLKS_PER_BIT-1 and bit_idx=0.
  - If rx_s=0 and HALF>0: go to START with cnt=HALF-1.
  - Otherwise stay in IDLE.
- **START:**
  - If cnt≠0: cnt--.
  - If cnt=0 and rx_s=0: go to DATA with cnt=CLKS_PER_BIT-1 and bit_idx=0.
  - If cnt=0 and rx_s=1: false start (glitch); go to IDLE with no output.
- **DATA:**
  - If cnt≠0: cnt--.
  - If cnt=0: shift[bit_idx] ← rx_s and cnt=CLKS_PER_BIT-1. If bit_idx=7, go to STOP; otherwise bit_idx++.
- **STOP:**
  - If cnt≠0: cnt--.
  - If cnt=0 and rx_s=1: data ← shift, valid ← 1, go to IDLE.
  - If cnt=0 and rx_s=0: frame_err=1 for this cycle, byte discarded, go to BREAK.
- **BREAK:** wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering a start.
- **Handshake:**
  - ack with valid=1 clears valid and overrun at the next edge.
  - New byte with valid=1 and ack=0: data is overwritten with the newest byte, valid stays 1, overrun is set.
  - New byte and ack in the same cycle: data takes the new byte, valid stays 1, overrun unchanged (the old byte was consumed).
  - ack with valid=0 is ignored.
- **Reset mid-frame:** the frame is aborted, the partial byte is lost, and all state is cleared. A frame already in flight on the line is not recovered. The next start edge after idle is received normally.

## Timing
- **Reset values:** data=8'h00, valid=0, frame_err=0, overrun=0, busy=0, state IDLE, cnt=0, bit_idx=0, shift=0, synchronizer flops = 1.
- **Latency:**
  - Let E be the edge where the first synchronizer flop captures the start bit low.
  - Start detection happens at edge E+2.
  - valid and data update at edge E+2+HALF+9·CLKS_PER_BIT.
  - For CLKS_PER_BIT=1, that is edge E+11.
- **Throughput:** the FSM is back in IDLE the cycle after the stop sample. Back-to-back frames with zero idle cycles between stop and next start are received without loss.
- **frame_err:** asserts in the cycle after the failing stop sample, exactly one cycle wide.
- **busy:** rises the cycle after start detection; falls when IDLE is re-entered.

## Test plan
- **Reset and single byte:** reset 2 cycles with rx=1 → all outputs 0. Then CLKS_PER_BIT=1, send frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → valid=1 and data=0xA5 at edge E+11; both hold until ack; valid=0 one cycle after ack.
- **Back-to-back with ack:** send 0x3C and 0xC3 with no idle gap, ack each byte the cycle valid rises → both bytes received in order, overrun stays 0, frame_err stays 0.
- **Overrun:** send 0x11 then 0x22 with no ack → data=0x22, valid=1, overrun=1. One ack → valid=0 and overrun=0.
- **Framing error / break:** send 0x5A with the stop bit low, then hold rx low for 5 more bit times → one-cycle frame_err pulse, valid stays 0, busy stays 1 until the line goes high. The next 0x5A frame is received correctly.
- **Glitch rejection:** CLKS_PER_BIT=16, 3-cycle low pulse on rx → returns to IDLE, no valid, no frame_err. Then frame 0x81 at 16 clocks per bit → data=0x81 at edge E+2+7+144.
- **Reset mid-frame:** assert reset during data bit 3 of 0xFF → all outputs return to reset values. After the line idles, frame 0x0F is received correctly with no overrun.

Source files
------------

// File: rtl/uart_rx_if.sv
// Host-side handshake bundle for the UART receiver.
//   data      : received byte, held stable while valid is high
//   valid     : a byte is waiting in data
//   ack       : host consumes the waiting byte
//   frame_err : single-cycle pulse when a stop bit was sampled low
//   overrun   : sticky, a byte was replaced before the host acked it
//   busy      : a frame is being received
// The receiver uses the master modport; the host uses the slave modport.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output data, valid, frame_err, overrun, busy,
    input  ack
  );

  modport slave (
    input  data, valid, frame_err, overrun, busy,
    output ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Synchronizes the asynchronous serial line, samples each bit at its
// midpoint, checks the stop bit and hands completed bytes to the host
// through a valid/ack holding register.
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high reset
//   rx    : asynchronous serial input, idle high
//   host  : uart_rx_if master (data, valid, ack, frame_err, overrun, busy)
// Parameter:
//   CLKS_PER_BIT : clocks per serial bit (>= 1)
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master host
);

  // Offset from the start edge to the middle of the start bit.
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Two-flop synchronizer, reset to the idle level so reset never looks
  // like a start bit.
  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             byte_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ferr_d    = 1'b0;
    byte_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          if (HALF == 0) begin
            // Detection already lands on the start-bit midpoint.
            state_d   = S_DATA;
            cnt_d     = CNT_FULL;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_START;
            cnt_d   = CNT_HALF;
          end
        end
      end

      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!rx_s) begin
          state_d   = S_DATA;
          cnt_d     = CNT_FULL;
          bit_idx_d = 3'd0;
        end else begin
          // Line went back high before mid-start: treat as a glitch.
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = CNT_FULL;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          byte_done = 1'b1;
          state_d   = S_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_BREAK;
        end
      end

      S_BREAK: begin
        // Hold off until the line returns high so a long low level is
        // not mistaken for a new start bit.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Holding register. A new byte always wins; overrun is only raised
    // when the previous byte was still unacknowledged.
    if (byte_done) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !host.ack) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && host.ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign host.data      = data_q;
  assign host.valid     = valid_q;
  assign host.frame_err = ferr_q;
  assign host.overrun   = ovr_q;
  assign host.busy      = (state_q != S_IDLE);

endmodule
